// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap/MRET sequencer.
// Writes mepc/mcause/mtval, reads mtvec (or mepc for MRET), then issues a
// one-cycle PC redirect and pipeline flush.
module trap_controller #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_enable,
  input  logic [2:0]      trap_status,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_value,
  input  logic            csr_ready,
  input  logic [XLEN-1:0] csr_read_data,
  output logic            trap_done,
  output logic            csr_write_enable,
  output logic [11:0]     csr_write_address,
  output logic [XLEN-1:0] csr_write_data,
  output logic [11:0]     csr_read_address,
  output logic [XLEN-1:0] trap_target,
  output logic            pc_redirect,
  output logic            pth_done_flush
);

  localparam int unsigned CAUSE_W = 4;

  localparam logic [2:0] TS_NONE     = 3'b000;
  localparam logic [2:0] TS_EBREAK   = 3'b001;
  localparam logic [2:0] TS_ECALL    = 3'b010;
  localparam logic [2:0] TS_MRET     = 3'b011;
  localparam logic [2:0] TS_MIS_INSN = 3'b100;
  localparam logic [2:0] TS_MIS_LD   = 3'b101;
  localparam logic [2:0] TS_MIS_ST   = 3'b110;
  localparam logic [2:0] TS_ILLEGAL  = 3'b111;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  // Direct-mode vector: the low two bits of the read value are dropped.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_MEPC   = 3'd1,
    W_MCAUSE = 3'd2,
    W_MTVAL  = 3'd3,
    R_MTVEC  = 3'd4,
    R_MEPC   = 3'd5,
    REDIRECT = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      cap_pc_q, cap_pc_d;
  logic [CAUSE_W-1:0]   cap_cause_q, cap_cause_d;
  logic [XLEN-1:0]      cap_tval_q, cap_tval_d;
  logic [XLEN-1:0]      trap_target_q, trap_target_d;

  // State and capture registers; everything holds while clk_enable is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cap_pc_q      <= '0;
      cap_cause_q   <= '0;
      cap_tval_q    <= '0;
      trap_target_q <= '0;
    end else if (clk_enable) begin
      state_q       <= state_d;
      cap_pc_q      <= cap_pc_d;
      cap_cause_q   <= cap_cause_d;
      cap_tval_q    <= cap_tval_d;
      trap_target_q <= trap_target_d;
    end
  end

  // Next-state, capture and state-decoded outputs.
  always_comb begin
    state_d           = state_q;
    cap_pc_d          = cap_pc_q;
    cap_cause_d       = cap_cause_q;
    cap_tval_d        = cap_tval_q;
    trap_target_d     = trap_target_q;
    trap_done         = 1'b0;
    csr_write_enable  = 1'b0;
    csr_write_address = '0;
    csr_write_data    = '0;
    csr_read_address  = '0;
    pc_redirect       = 1'b0;
    pth_done_flush    = 1'b0;

    unique case (state_q)
      IDLE: begin
        trap_done = (trap_status == TS_NONE);
        if (trap_status == TS_MRET) begin
          state_d = R_MEPC;
        end else if (trap_status != TS_NONE) begin
          state_d  = W_MEPC;
          cap_pc_d = trap_pc;
          unique case (trap_status)
            TS_EBREAK:   begin cap_cause_d = CAUSE_W'(3);  cap_tval_d = '0;         end
            TS_ECALL:    begin cap_cause_d = CAUSE_W'(11); cap_tval_d = '0;         end
            TS_MIS_INSN: begin cap_cause_d = CAUSE_W'(0);  cap_tval_d = trap_value; end
            TS_MIS_LD:   begin cap_cause_d = CAUSE_W'(4);  cap_tval_d = trap_value; end
            TS_MIS_ST:   begin cap_cause_d = CAUSE_W'(6);  cap_tval_d = trap_value; end
            TS_ILLEGAL:  begin cap_cause_d = CAUSE_W'(2);  cap_tval_d = trap_value; end
            default:     begin cap_cause_d = '0;           cap_tval_d = '0;         end
          endcase
        end
      end
      W_MEPC: begin
        csr_write_enable  = 1'b1;
        csr_write_address = CSR_MEPC;
        csr_write_data    = cap_pc_q;
        if (csr_ready) state_d = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_write_enable  = 1'b1;
        csr_write_address = CSR_MCAUSE;
        csr_write_data    = XLEN'(cap_cause_q);
        if (csr_ready) state_d = W_MTVAL;
      end
      W_MTVAL: begin
        csr_write_enable  = 1'b1;
        csr_write_address = CSR_MTVAL;
        csr_write_data    = cap_tval_q;
        if (csr_ready) state_d = R_MTVEC;
      end
      R_MTVEC: begin
        csr_read_address = CSR_MTVEC;
        trap_target_d    = csr_read_data & ALIGN_MASK;
        state_d          = REDIRECT;
      end
      R_MEPC: begin
        csr_read_address = CSR_MEPC;
        trap_target_d    = csr_read_data & ALIGN_MASK;
        state_d          = REDIRECT;
      end
      REDIRECT: begin
        trap_done      = 1'b1;
        pc_redirect    = 1'b1;
        pth_done_flush = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign trap_target = trap_target_q;

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed vectors for the trap/MRET sequencer.
module tb_trap_controller;

  logic        clk;
  logic        reset_n;
  logic        clk_enable;
  logic [2:0]  trap_status;
  logic [31:0] trap_pc;
  logic [31:0] trap_value;
  logic        csr_ready;
  logic [31:0] csr_read_data;
  logic        trap_done;
  logic        csr_write_enable;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic [11:0] csr_read_address;
  logic [31:0] trap_target;
  logic        pc_redirect;
  logic        pth_done_flush;

  logic [31:0] mtvec_val;
  logic [31:0] mepc_val;
  logic [43:0] wr_q[$];

  int n_total;
  int n_bad;

  trap_controller #(.XLEN(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .clk_enable        (clk_enable),
    .trap_status       (trap_status),
    .trap_pc           (trap_pc),
    .trap_value        (trap_value),
    .csr_ready         (csr_ready),
    .csr_read_data     (csr_read_data),
    .trap_done         (trap_done),
    .csr_write_enable  (csr_write_enable),
    .csr_write_address (csr_write_address),
    .csr_write_data    (csr_write_data),
    .csr_read_address  (csr_read_address),
    .trap_target       (trap_target),
    .pc_redirect       (pc_redirect),
    .pth_done_flush    (pth_done_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal CSR file read port.
  always_comb begin
    case (csr_read_address)
      12'h305: csr_read_data = mtvec_val;
      12'h341: csr_read_data = mepc_val;
      default: csr_read_data = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence from its detect cycle back to IDLE, collecting accepted writes.
  task automatic run_seq(input int stall_n, input int hold_n, input logic [2:0] noise,
                         output int low, output int redir, output int flush,
                         output logic [31:0] tgt);
    int  stall_left;
    int  hold_left;
    bit  seen;
    bit  done;
    stall_left = stall_n;
    hold_left  = hold_n;
    seen  = 1'b0;
    done  = 1'b0;
    low   = 0;
    redir = 0;
    flush = 0;
    tgt   = 32'hx;
    wr_q.delete();
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc == 1) trap_status = noise;
      else if (cyc > 1) trap_status = 3'b000;
      csr_ready = 1'b1;
      if (stall_left > 0 && csr_write_enable && csr_write_address == 12'h342) begin
        csr_ready = 1'b0;
        stall_left--;
        check("stall_addr", 32'(csr_write_address), 32'h342);
        check("stall_data", csr_write_data, 32'd4);
      end
      clk_enable = 1'b1;
      if (pc_redirect && hold_left > 0) begin
        clk_enable = 1'b0;
        hold_left--;
      end
      #1;
      if (!trap_done) low++;
      if (pth_done_flush) flush++;
      if (csr_write_enable && csr_ready) wr_q.push_back({csr_write_address, csr_write_data});
      if (pc_redirect) begin
        redir++;
        seen = 1'b1;
        tgt  = trap_target;
      end else if (seen) begin
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    clk_enable = 1'b1;
    csr_ready  = 1'b1;
    check("seq_completes", 32'(done), 32'd1);
  endtask

  task automatic check_writes(input logic [31:0] pc, input logic [31:0] cause,
                              input logic [31:0] tval);
    check("wr_count", 32'(wr_q.size()), 32'd3);
    if (wr_q.size() == 3) begin
      check("wr0_addr", 32'(wr_q[0][43:32]), 32'h341);
      check("wr0_data", wr_q[0][31:0], pc);
      check("wr1_addr", 32'(wr_q[1][43:32]), 32'h342);
      check("wr1_data", wr_q[1][31:0], cause);
      check("wr2_addr", 32'(wr_q[2][43:32]), 32'h343);
      check("wr2_data", wr_q[2][31:0], tval);
    end
  endtask

  initial begin
    int          low, redir, flush;
    logic [31:0] tgt;
    n_total     = 0;
    n_bad       = 0;
    reset_n     = 1'b0;
    clk_enable  = 1'b1;
    trap_status = 3'b000;
    trap_pc     = 32'h0;
    trap_value  = 32'h0;
    csr_ready   = 1'b1;
    mtvec_val   = 32'h0000_0203;
    mepc_val    = 32'h0000_0456;

    // Reset state.
    #12;
    check("rst_trap_done", 32'(trap_done), 32'd1);
    check("rst_we", 32'(csr_write_enable), 32'd0);
    check("rst_redirect", 32'(pc_redirect), 32'd0);
    check("rst_flush", 32'(pth_done_flush), 32'd0);
    check("rst_target", trap_target, 32'h0);
    check("rst_raddr", 32'(csr_read_address), 32'h0);
    reset_n = 1'b1;
    tick();

    // ECALL: writes mepc/mcause/mtval, vectors to aligned mtvec.
    trap_status = 3'b010;
    trap_pc     = 32'h0000_0100;
    trap_value  = 32'hDEAD_BEEF;
    run_seq(0, 0, 3'b000, low, redir, flush, tgt);
    check("ecall_low", 32'(low), 32'd5);
    check("ecall_redir", 32'(redir), 32'd1);
    check("ecall_flush", 32'(flush), 32'd1);
    check("ecall_target", tgt, 32'h0000_0200);
    check_writes(32'h100, 32'd11, 32'h0);
    check("idle_after_ecall", 32'(trap_done), 32'd1);

    // MRET: reads mepc, no writes.
    trap_status = 3'b011;
    run_seq(0, 0, 3'b000, low, redir, flush, tgt);
    check("mret_low", 32'(low), 32'd2);
    check("mret_redir", 32'(redir), 32'd1);
    check("mret_target", tgt, 32'h0000_0454);
    check("mret_wr_count", 32'(wr_q.size()), 32'd0);

    // Misaligned load with three ready-low cycles on mcause.
    trap_status = 3'b101;
    trap_pc     = 32'h0000_0880;
    trap_value  = 32'h1000_0003;
    run_seq(3, 0, 3'b000, low, redir, flush, tgt);
    check("misld_low", 32'(low), 32'd8);
    check("misld_redir", 32'(redir), 32'd1);
    check("misld_target", tgt, 32'h0000_0200);
    check_writes(32'h880, 32'd4, 32'h1000_0003);

    // Reset asserted while in W_MTVAL aborts the trap.
    trap_status = 3'b010;
    trap_pc     = 32'h0000_0300;
    tick();
    trap_status = 3'b000;
    tick();
    tick();
    check("pre_rst_waddr", 32'(csr_write_address), 32'h343);
    reset_n = 1'b0;
    #1;
    check("midrst_trap_done", 32'(trap_done), 32'd1);
    check("midrst_we", 32'(csr_write_enable), 32'd0);
    check("midrst_waddr", 32'(csr_write_address), 32'h0);
    check("midrst_redirect", 32'(pc_redirect), 32'd0);
    check("midrst_target", trap_target, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    trap_status = 3'b010;
    trap_pc     = 32'h0000_0400;
    run_seq(0, 0, 3'b000, low, redir, flush, tgt);
    check("postrst_low", 32'(low), 32'd5);
    check("postrst_target", tgt, 32'h0000_0200);
    check_writes(32'h400, 32'd11, 32'h0);

    // EBREAK: status changes in W_MEPC, redirect frozen for two cycles.
    trap_status = 3'b001;
    trap_pc     = 32'h0000_0500;
    trap_value  = 32'h0000_ABCD;
    run_seq(0, 2, 3'b111, low, redir, flush, tgt);
    check("hold_low", 32'(low), 32'd5);
    check("hold_redir", 32'(redir), 32'd3);
    check("hold_flush", 32'(flush), 32'd3);
    check("hold_target", tgt, 32'h0000_0200);
    check_writes(32'h500, 32'd3, 32'h0);
    check("hold_idle_we", 32'(csr_write_enable), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
